// File: rtl/vga_res_ctrl.sv
// Resolution controller for vga_clk_gen: switch sync/debounce, reconfiguration
// handshake with timeout/retry, and pixel-domain reset release after settling.

package vga_res_pkg;
    typedef enum logic {
        VGA_RES_800_600   = 1'b0,
        VGA_RES_1280_1024 = 1'b1
    } vga_resolution_e;
endpackage

module vga_res_ctrl
    import vga_res_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned TIMEOUT_CYCLES  = 10000000,
    parameter int unsigned SETTLE_CYCLES   = 16
) (
    input  logic            clk_100m_i,
    input  logic            arstn_i,
    input  logic            res_sel_i,
    output vga_resolution_e resolution_o,
    output logic            req_o,
    input  logic            clk_valid_i,
    output logic            pix_rstn_o,
    output logic            busy_o,
    output logic            err_o
);

    localparam int unsigned DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned TO_W  = (TIMEOUT_CYCLES  > 1) ? $clog2(TIMEOUT_CYCLES)  : 1;
    localparam int unsigned SET_W = (SETTLE_CYCLES   > 1) ? $clog2(SETTLE_CYCLES)   : 1;

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        INIT_S,
        REQ_S,
        WAIT_S,
        SETTLE_S,
        RUN_S
    } state_e;

    state_e          r_state;
    state_e          w_next;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_sel_db;
    logic [DEB_W-1:0] r_deb_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic [SET_W-1:0] r_set_cnt;
    vga_resolution_e r_res;
    logic            r_req;
    logic            r_pix_rstn;
    logic            r_busy;
    logic            r_err;
    vga_resolution_e w_sel_res;
    logic            w_accept;
    logic            w_timeout;

    assign w_sel_res = r_sel_db ? VGA_RES_1280_1024 : VGA_RES_800_600;
    assign w_accept  = (r_state == WAIT_S) && clk_valid_i;
    assign w_timeout = (r_state == WAIT_S) && !clk_valid_i && (r_to_cnt == TO_LAST);

    // Two-flop synchroniser followed by a no-partial-credit debounce counter
    always_ff @(posedge clk_100m_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_sel_db  <= 1'b0;
            r_deb_cnt <= '0;
        end else begin
            r_sync1 <= res_sel_i;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_sel_db) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DEB_LAST) begin
                r_sel_db  <= r_sync2;
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + DEB_W'(1);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            INIT_S:   w_next = REQ_S;
            REQ_S:    w_next = WAIT_S;
            WAIT_S: begin
                if (clk_valid_i)             w_next = SETTLE_S;
                else if (r_to_cnt == TO_LAST) w_next = REQ_S;
            end
            SETTLE_S: if (r_set_cnt == SET_LAST) w_next = RUN_S;
            RUN_S:    if (w_sel_res != r_res)    w_next = REQ_S;
            default:  w_next = INIT_S;
        endcase
    end

    // Outputs are registered from the next state so they align with r_state
    always_ff @(posedge clk_100m_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state    <= INIT_S;
            r_req      <= 1'b0;
            r_pix_rstn <= 1'b0;
            r_busy     <= 1'b1;
            r_res      <= VGA_RES_800_600;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_req      <= (w_next == REQ_S);
            r_pix_rstn <= (w_next == RUN_S);
            r_busy     <= (w_next != RUN_S);
            if ((w_next == REQ_S) && (r_state != REQ_S)) begin
                r_res <= w_sel_res;
            end
            if (w_accept) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_100m_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_to_cnt  <= '0;
            r_set_cnt <= '0;
        end else begin
            if (r_state == REQ_S) begin
                r_to_cnt <= '0;
            end else if ((r_state == WAIT_S) && (r_to_cnt != TO_LAST)) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
            if (w_accept) begin
                r_set_cnt <= '0;
            end else if ((r_state == SETTLE_S) && (r_set_cnt != SET_LAST)) begin
                r_set_cnt <= r_set_cnt + SET_W'(1);
            end
        end
    end

    assign resolution_o = r_res;
    assign req_o        = r_req;
    assign pix_rstn_o   = r_pix_rstn;
    assign busy_o       = r_busy;
    assign err_o        = r_err;

endmodule

// File: tb/tb_vga_res_ctrl.sv
// Scoreboard bench for vga_res_ctrl: stimulus queues expected req/run events,
// a negedge monitor pops and checks them as the DUT produces them.

module tb_vga_res_ctrl;
    import vga_res_pkg::*;

    localparam int EV_REQ = 0;
    localparam int EV_RUN = 1;

    typedef struct {
        int kind;
        int cyc;
        int res;
        int err;
    } ev_t;

    logic            clk = 1'b0;
    logic            arstn;
    logic            res_sel;
    logic            clk_valid;
    vga_resolution_e resolution;
    logic            req;
    logic            pix_rstn;
    logic            busy;
    logic            err;

    int   cyc;
    int   n_tests = 0;
    int   n_fail  = 0;
    ev_t  exp_q[$];
    logic pix_prev = 1'b0;

    vga_res_ctrl #(
        .DEBOUNCE_CYCLES(8),
        .TIMEOUT_CYCLES (64),
        .SETTLE_CYCLES  (4)
    ) dut (
        .clk_100m_i  (clk),
        .arstn_i     (arstn),
        .res_sel_i   (res_sel),
        .resolution_o(resolution),
        .req_o       (req),
        .clk_valid_i (clk_valid),
        .pix_rstn_o  (pix_rstn),
        .busy_o      (busy),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    // Cycle k = state after the k-th rising edge following reset release
    always @(posedge clk or negedge arstn) begin
        if (!arstn) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int kind, input int c, input int res, input int e);
        ev_t ev;
        ev.kind = kind;
        ev.cyc  = c;
        ev.res  = res;
        ev.err  = e;
        exp_q.push_back(ev);
    endtask

    task automatic goto(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_valid(input int t);
        goto(t);
        clk_valid = 1'b1;
        @(negedge clk);
        clk_valid = 1'b0;
    endtask

    task automatic handle(input int kind);
        ev_t ev;
        if (exp_q.size() == 0) begin
            chk(kind == EV_REQ ? "unexpected_req" : "unexpected_run", 1, 0);
        end else begin
            ev = exp_q.pop_front();
            chk("ev_kind",  kind, ev.kind);
            chk("ev_cycle", cyc, ev.cyc);
            chk("ev_res",   int'(resolution), ev.res);
            chk("ev_err",   int'(err), ev.err);
            if (kind == EV_REQ) chk("req_pix_low", int'(pix_rstn), 0);
            else                chk("run_busy_low", int'(busy), 0);
        end
    endtask

    always @(negedge clk) begin
        if (arstn) begin
            if (req) handle(EV_REQ);
            if (pix_rstn && !pix_prev) handle(EV_RUN);
        end
        pix_prev = pix_rstn;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int r;
        int t;
        arstn     = 1'b0;
        res_sel   = 1'b0;
        clk_valid = 1'b0;
        step(3);
        chk("rst_req",  int'(req), 0);
        chk("rst_res",  int'(resolution), 0);
        chk("rst_pix",  int'(pix_rstn), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_err",  int'(err), 0);

        // Boot
        push(EV_REQ, 1, 0, 0);
        push(EV_RUN, 17, 0, 0);
        arstn = 1'b1;
        pulse_valid(12);
        goto(16);
        chk("boot_pix_before", int'(pix_rstn), 0);
        chk("boot_busy_before", int'(busy), 1);

        // Bounce: no request may appear
        goto(20);
        for (int i = 0; i < 10; i++) begin
            res_sel = ~res_sel;
            step(3);
        end
        res_sel = 1'b0;
        step(12);
        chk("bounce_pix",  int'(pix_rstn), 1);
        chk("bounce_busy", int'(busy), 0);
        chk("bounce_res",  int'(resolution), 0);

        // Clean switch to 1280x1024
        s = cyc;
        res_sel = 1'b1;
        push(EV_REQ, s + 11, 1, 0);
        goto(s + 14);
        chk("sw_pix_wait",  int'(pix_rstn), 0);
        chk("sw_busy_wait", int'(busy), 1);
        t = s + 20;
        push(EV_RUN, t + 5, 1, 0);
        pulse_valid(t);
        goto(t + 4);
        chk("sw_pix_settle", int'(pix_rstn), 0);

        // Timeout and retry
        goto(t + 8);
        s = cyc;
        res_sel = 1'b0;
        r = s + 11;
        push(EV_REQ, r, 0, 0);
        push(EV_REQ, r + 65, 0, 1);
        goto(r + 64);
        chk("to_err_before", int'(err), 0);
        goto(r + 66);
        chk("to_err_set", int'(err), 1);
        t = r + 70;
        push(EV_RUN, t + 5, 0, 0);
        pulse_valid(t);
        chk("to_err_clear", int'(err), 0);

        // Switch change while waiting for valid
        goto(t + 8);
        s = cyc;
        res_sel = 1'b1;
        r = s + 11;
        push(EV_REQ, r, 1, 0);
        goto(r + 3);
        res_sel = 1'b0;
        goto(r + 19);
        chk("cw_res_hold", int'(resolution), 1);
        t = r + 20;
        push(EV_RUN, t + 5, 1, 0);
        push(EV_REQ, t + 6, 0, 0);
        pulse_valid(t);
        push(EV_RUN, t + 15, 0, 0);
        pulse_valid(t + 10);

        // Reset in WAIT_S after a timeout
        goto(t + 20);
        s = cyc;
        res_sel = 1'b1;
        r = s + 11;
        push(EV_REQ, r, 1, 0);
        push(EV_REQ, r + 65, 1, 1);
        goto(r + 68);
        chk("mr_err_pre", int'(err), 1);
        res_sel = 1'b0;
        #2 arstn = 1'b0;
        #1;
        chk("mr_pix",  int'(pix_rstn), 0);
        chk("mr_req",  int'(req), 0);
        chk("mr_err",  int'(err), 0);
        chk("mr_res",  int'(resolution), 0);
        chk("mr_busy", int'(busy), 1);
        step(3);
        push(EV_REQ, 1, 0, 0);
        push(EV_RUN, 17, 0, 0);
        arstn = 1'b1;
        pulse_valid(12);
        goto(22);

        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_res_ctrl.md
Name: vga_res_ctrl

Overview:
Upstream controller for vga_clk_gen, in the clk_100m_i domain. It synchronises and debounces the board resolution switch, and drives vga_clk_gen with a stable resolution_o and a one-cycle req_o. It waits for the valid pulse from vga_clk_gen, then releases the pixel-domain timing generator from reset. It also performs the initial clock configuration after reset and retries on timeout.

Parameters:
DEBOUNCE_CYCLES, 1000000, stable cycles of synced switch required before accepting a change (10 ms at 100 MHz)
TIMEOUT_CYCLES, 10000000, cycles to wait for clk_valid_i before re-issuing req_o (100 ms)
SETTLE_CYCLES, 16, cycles after clk_valid_i before pix_rstn_o is released (must be >= 1)

Ports:
clk_100m_i  in  1  system clock, 100 MHz
arstn_i  in  1  asynchronous active-low reset
res_sel_i  in  1  raw asynchronous switch: 0 = VGA_RES_800_600, 1 = VGA_RES_1280_1024
resolution_o  out  vga_resolution_e  target resolution, to vga_clk_gen resolution_i
req_o  out  1  one-cycle reconfiguration request, to vga_clk_gen req_i
clk_valid_i  in  1  one-cycle done pulse from vga_clk_gen valid_o
pix_rstn_o  out  1  active-low reset for the pixel timing generator
busy_o  out  1  high while not in RUN_S
err_o  out  1  sticky timeout flag

Behaviour:
- Clocking and reset: one clock, clk_100m_i. Reset arstn_i is asynchronous and active-low; all flops reset on negedge arstn_i.
- Reset values:
  - req_o = 0, resolution_o = VGA_RES_800_600, pix_rstn_o = 0, busy_o = 1, err_o = 0.
  - Sync flops = 0, debounced select = 0, all counters = 0, state = INIT_S.
- Synchroniser: 2-flop on res_sel_i. sel_sync reflects res_sel_i 2 cycles later.
- Debounce:
  - If sel_sync == sel_db, deb_cnt <= 0.
  - Otherwise deb_cnt increments. When deb_cnt == DEBOUNCE_CYCLES-1 with the mismatch still present, sel_db <= sel_sync and deb_cnt <= 0.
  - Any return to equality before terminal count clears deb_cnt; there is no partial credit.
  - deb_cnt width is clog2(DEBOUNCE_CYCLES) and never wraps.
- FSM (registered state; outputs are decoded from the registered state):
  - INIT_S: → REQ_S unconditionally. It exists so req_o is never high during or at reset.
  - REQ_S:
    - Entry latch: resolution_o <= sel_db ? VGA_RES_1280_1024 : VGA_RES_800_600 when entering REQ_S.
    - req_o = 1 for exactly this one cycle.
    - Next cycle → WAIT_S with to_cnt <= 0.
  - WAIT_S:
    - If clk_valid_i: → SETTLE_S, err_o <= 0, set_cnt <= 0.
    - Else if to_cnt == TIMEOUT_CYCLES-1: err_o <= 1, → REQ_S (retry; resolution_o re-latched from the current sel_db).
    - Else to_cnt increments.
    - clk_valid_i takes priority over timeout in the same cycle.
  - SETTLE_S: set_cnt increments. When set_cnt == SETTLE_CYCLES-1, → RUN_S.
  - RUN_S:
    - If the resolution mapped from sel_db != resolution_o: → REQ_S.
    - Else stay in RUN_S.
- Output decoding:
  - pix_rstn_o = 1 only in RUN_S; registered, so high on the first RUN_S cycle.
  - busy_o = (state != RUN_S).
- resolution_o is constant from REQ_S through the end of WAIT_S (vga_clk_gen samples it combinationally during its AXI write).
- Switch changes during REQ_S/WAIT_S/SETTLE_S are not acted on until RUN_S. The mismatch check in RUN_S then triggers REQ_S on the next cycle, with the latest sel_db.
- clk_valid_i outside WAIT_S is ignored.
- Retries are unlimited. err_o stays 1 until a clk_valid_i is accepted in WAIT_S.
- Reset mid-operation: all outputs return to reset values immediately (asynchronously). After release the sequence restarts from INIT_S.
- Latency from a valid pulse in WAIT_S at cycle t: pix_rstn_o = 1 at cycle t+1+SETTLE_CYCLES.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=8, TIMEOUT_CYCLES=64, SETTLE_CYCLES=4.
1. Boot: res_sel_i=0, release arstn_i at cycle 0 → req_o=1 only at cycle 1, resolution_o=VGA_RES_800_600. Then clk_valid_i at cycle 12 → pix_rstn_o=1 and busy_o=0 from cycle 17.
2. Bounce: in RUN_S, toggle res_sel_i every 3 cycles for 30 cycles, then hold 0 → req_o never asserts; resolution_o, pix_rstn_o=1 and busy_o=0 unchanged.
3. Clean switch: res_sel_i 0→1 held in RUN_S → one req_o pulse about 2+8+1 cycles later with resolution_o=VGA_RES_1280_1024. pix_rstn_o=0 from the REQ_S cycle until 5 cycles after clk_valid_i.
4. Timeout: after req_o, no clk_valid_i for 64 cycles → err_o=1 and a second req_o pulse. Then clk_valid_i → err_o=0, and pix_rstn_o=1 five cycles later.
5. Change during wait: with resolution_o=1280_1024 in WAIT_S, set res_sel_i=0 stable → resolution_o holds 1280_1024 until valid. One cycle after RUN_S entry, req_o pulses with resolution_o=800_600.
6. Reset mid-WAIT_S: drop arstn_i → pix_rstn_o=0, req_o=0, err_o=0, resolution_o=800_600 immediately. After release, req_o pulses at cycle 1.
